// File: rtl/uart_pkg.sv
// Shared definitions for the uart loopback bridge.
//   DATA_W_DEF     : default rx/tx word width
//   bridge_state_e : handshake FSM encoding
//   lvl_w()        : width of a 0..depth occupancy count
package uart_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACK  = 2'd1,
    ST_WAIT_DONE = 2'd2
  } bridge_state_e;

  // One extra bit so the count can hold DEPTH itself.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_loopback_bridge_sync_fifo_lvl.sv
// sync_fifo_lvl: DEPTH x DATA_W synchronous FIFO with registered level/flags.
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   i_flush             clears pointers/level; beats write and read
//   i_wr, i_wr_data     write request (ignored when full)
//   i_rd                read request (ignored when empty); advances rd pointer
//   o_rd_data           word at the read pointer (show-ahead)
//   o_level             occupancy 0..DEPTH
//   o_empty, o_full, o_almost_full  flags registered alongside o_level
module sync_fifo_lvl
  import uart_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_flush,
  input  logic                      i_wr,
  input  logic [DATA_W-1:0]         i_wr_data,
  input  logic                      i_rd,
  output logic [DATA_W-1:0]         o_rd_data,
  output logic [lvl_w(DEPTH)-1:0]   o_level,
  output logic                      o_empty,
  output logic                      o_full,
  output logic                      o_almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              r_empty, r_full, r_af;
  logic              w_wr_en, w_rd_en;
  logic [LW-1:0]     w_level_nxt;

  // Full is the registered flag, so a write in the same cycle as a pop
  // from a full FIFO is still dropped.
  assign w_wr_en = i_wr & ~r_full  & ~i_flush;
  assign w_rd_en = i_rd & ~r_empty & ~i_flush;

  always_comb begin
    w_level_nxt = r_level;
    if (i_flush) begin
      w_level_nxt = '0;
    end else begin
      case ({w_wr_en, w_rd_en})
        2'b10:   w_level_nxt = r_level + 1'b1;
        2'b01:   w_level_nxt = r_level - 1'b1;
        default: w_level_nxt = r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_af     <= 1'b0;
    end else begin
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
      r_full  <= (w_level_nxt == LW'(DEPTH));
      r_af    <= (w_level_nxt >= LW'(AF_THRESH));
    end
  end

  assign o_rd_data     = r_mem[r_rd_ptr];
  assign o_level       = r_level;
  assign o_empty       = r_empty;
  assign o_full        = r_full;
  assign o_almost_full = r_af;

endmodule

// File: rtl/uart_loopback_bridge.sv
// uart_loopback_bridge: buffers rx words and issues them one at a time to
// the transmitter, locking after each issue until ready drops and rises.
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_rx_data, i_rx_valid     received word + one-cycle strobe
//   i_loop_en                 accept rx strobes when high
//   i_flush                   synchronous FIFO flush (handshake unaffected)
//   i_tx_ready                transmitter idle
//   o_tx_data, o_tx_valid     issued word + one-cycle issue pulse
//   o_level, o_empty, o_full, o_almost_full  FIFO status
//   o_overflow, o_drop_cnt    drop pulse and saturating drop count
//   o_timeout                 pulse when ready never fell after an issue
//
// state        | meaning
// ST_IDLE      | free to pop the next word when tx is ready
// ST_WAIT_ACK  | word issued, waiting for ready to fall (or timeout)
// ST_WAIT_DONE | transmitter busy, waiting for ready to rise again
module uart_loopback_bridge
  import uart_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = 16,
  parameter int AF_THRESH   = 14,
  parameter int ACK_TIMEOUT = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [DATA_W-1:0]         i_rx_data,
  input  logic                      i_rx_valid,
  input  logic                      i_loop_en,
  input  logic                      i_flush,
  input  logic                      i_tx_ready,
  output logic [DATA_W-1:0]         o_tx_data,
  output logic                      o_tx_valid,
  output logic [lvl_w(DEPTH)-1:0]   o_level,
  output logic                      o_empty,
  output logic                      o_full,
  output logic                      o_almost_full,
  output logic                      o_overflow,
  output logic [CNT_W-1:0]          o_drop_cnt,
  output logic                      o_timeout
);

  localparam bit TO_EN = (ACK_TIMEOUT != 0);
  localparam int TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  // Loaded on the issue edge; the timeout fires on the edge that finds it
  // at zero, i.e. ACK_TIMEOUT edges after the issue.
  localparam logic [TO_W-1:0] TO_LOAD = TO_EN ? TO_W'(ACK_TIMEOUT - 1) : '0;

  bridge_state_e     r_state, w_state_nxt;
  logic              r_first;
  logic [TO_W-1:0]   r_to_cnt;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_valid, r_overflow, r_timeout;
  logic [CNT_W-1:0]  r_drop_cnt;

  logic              w_wr, w_pop, w_to_fire;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_empty, w_full;

  assign w_wr = i_rx_valid & i_loop_en & ~i_flush;

  sync_fifo_lvl #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF_THRESH)
  ) u_fifo (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_flush       (i_flush),
    .i_wr          (w_wr),
    .i_wr_data     (i_rx_data),
    .i_rd          (w_pop),
    .o_rd_data     (w_rd_data),
    .o_level       (o_level),
    .o_empty       (w_empty),
    .o_full        (w_full),
    .o_almost_full (o_almost_full)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_to_fire   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_tx_ready && !w_empty && !i_flush) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // r_first masks ready on the edge right after the issue.
        if (!r_first && !i_tx_ready) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (TO_EN && (r_to_cnt == '0)) begin
          w_to_fire   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_tx_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_first    <= 1'b0;
      r_to_cnt   <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_timeout  <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_first    <= w_pop;
      r_tx_valid <= w_pop;
      r_timeout  <= w_to_fire;
      r_overflow <= w_wr & w_full;
      if (w_pop) begin
        r_tx_data <= w_rd_data;
        r_to_cnt  <= TO_LOAD;
      end else if (r_state == ST_WAIT_ACK && r_to_cnt != '0) begin
        r_to_cnt <= r_to_cnt - 1'b1;
      end
      if (w_wr && w_full && !(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;
  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_overflow = r_overflow;
  assign o_drop_cnt = r_drop_cnt;
  assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_uart_loopback_bridge.sv
module tb_uart_loopback_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid, loop_en, flush, tx_ready;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic [4:0]  o_level;
  logic        o_empty, o_full, o_almost_full, o_overflow, o_timeout;
  logic [15:0] o_drop_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_loopback_bridge #(
    .DATA_W(8), .DEPTH(16), .AF_THRESH(14), .ACK_TIMEOUT(8), .CNT_W(16)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_rx_data     (rx_data),
    .i_rx_valid    (rx_valid),
    .i_loop_en     (loop_en),
    .i_flush       (flush),
    .i_tx_ready    (tx_ready),
    .o_tx_data     (o_tx_data),
    .o_tx_valid    (o_tx_valid),
    .o_level       (o_level),
    .o_empty       (o_empty),
    .o_full        (o_full),
    .o_almost_full (o_almost_full),
    .o_overflow    (o_overflow),
    .o_drop_cnt    (o_drop_cnt),
    .o_timeout     (o_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_issue(output bit got);
    got = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (o_tx_valid) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Transmitter model: ready high until issue, stays high two more edges,
  // then low for lo edges, then high again.
  task automatic serve(input logic [7:0] exp, input string tag, input int lo);
    bit got;
    int pulses;
    tx_ready = 1'b1;
    wait_issue(got);
    chk({tag, "_issued"}, got, 1);
    chk({tag, "_data"}, o_tx_data, exp);
    tick();
    chk({tag, "_one_cycle"}, o_tx_valid, 0);
    tick();
    pulses = o_tx_valid;
    tx_ready = 1'b0;
    repeat (lo) begin
      tick();
      pulses += o_tx_valid;
    end
    chk({tag, "_no_dup"}, pulses, 0);
    tx_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int cnt;

    rst_n = 1'b0; rx_data = '0; rx_valid = 0; loop_en = 1; flush = 0; tx_ready = 1;
    repeat (2) tick();
    chk("rst_level", o_level, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_full", o_full, 0);
    chk("rst_af", o_almost_full, 0);
    chk("rst_valid", o_tx_valid, 0);
    chk("rst_drop", o_drop_cnt, 0);
    rst_n = 1'b1;
    tick();

    // basic echo
    push(8'h55);
    chk("echo_level", o_level, 1);
    chk("echo_not_yet", o_tx_valid, 0);
    tick();
    chk("echo_valid", o_tx_valid, 1);
    chk("echo_data", o_tx_data, 8'h55);
    chk("echo_level0", o_level, 0);
    tx_ready = 1'b0;
    tick();
    chk("echo_one_cycle", o_tx_valid, 0);
    cnt = 0;
    repeat (10) begin tick(); cnt += o_tx_valid + o_timeout; end
    tx_ready = 1'b1;
    repeat (5) begin tick(); cnt += o_tx_valid + o_timeout; end
    chk("echo_single_pulse", cnt, 0);

    // burst with slow transmitter
    tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push(8'(i));
    chk("burst_level", o_level, 5);
    for (int i = 1; i <= 5; i++) serve(8'(i), $sformatf("burst%0d", i), 100);

    // simultaneous write and pop at level 3
    tx_ready = 1'b0;
    push(8'hA1); push(8'hA2); push(8'hA3);
    tx_ready = 1'b1;
    tick();
    chk("simul_pre_level", o_level, 3);
    chk("simul_pre_valid", o_tx_valid, 0);
    rx_data = 8'hA4; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    chk("simul_level", o_level, 3);
    chk("simul_valid", o_tx_valid, 1);
    chk("simul_data", o_tx_data, 8'hA1);
    tick(); tick();
    tx_ready = 1'b0;
    repeat (3) tick();
    serve(8'hA2, "simul_a2", 3);
    serve(8'hA3, "simul_a3", 3);
    serve(8'hA4, "simul_a4", 3);

    // wrap-around: 40 words through a 16-deep FIFO
    for (int r = 0; r < 4; r++) begin
      tx_ready = 1'b0;
      for (int k = 0; k < 10; k++) push(8'(8'h40 + r * 10 + k));
      for (int k = 0; k < 10; k++)
        serve(8'(8'h40 + r * 10 + k), $sformatf("wrap%0d", r * 10 + k), 3);
    end

    // overflow
    tx_ready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      rx_data = 8'(i); rx_valid = 1'b1;
      tick();
      cnt += o_overflow;
      if (i < 16) chk($sformatf("af_at_%0d", i + 1), o_almost_full, (i + 1 >= 14));
    end
    rx_valid = 1'b0;
    tick();
    cnt += o_overflow;
    chk("ovf_pulses", cnt, 4);
    chk("ovf_full", o_full, 1);
    chk("ovf_level", o_level, 16);
    chk("ovf_drop_cnt", o_drop_cnt, 4);

    // loop_en low: strobes ignored, not counted as drops
    loop_en = 1'b0;
    cnt = 0;
    repeat (3) begin push(8'hEE); cnt += o_overflow; end
    tick();
    cnt += o_overflow;
    chk("loopoff_level", o_level, 16);
    chk("loopoff_drop", o_drop_cnt, 4);
    chk("loopoff_ovf", cnt, 0);
    loop_en = 1'b1;

    // flush while full, with a concurrent strobe
    flush = 1'b1; rx_valid = 1'b1; rx_data = 8'h99;
    tick();
    flush = 1'b0; rx_valid = 1'b0;
    chk("flush16_level", o_level, 0);
    chk("flush16_empty", o_empty, 1);
    chk("flush16_full", o_full, 0);
    chk("flush16_af", o_almost_full, 0);

    // acknowledge timeout
    push(8'hC1); push(8'hC2);
    tx_ready = 1'b1;
    wait_issue(got);
    chk("to_issued", got, 1);
    chk("to_data", o_tx_data, 8'hC1);
    cnt = 0;
    repeat (7) begin tick(); cnt += o_timeout + o_tx_valid; end
    chk("to_early", cnt, 0);
    tick();
    chk("to_pulse", o_timeout, 1);
    tick();
    chk("to_pulse_end", o_timeout, 0);
    chk("to_next_valid", o_tx_valid, 1);
    chk("to_next_data", o_tx_data, 8'hC2);
    tick(); tick();
    tx_ready = 1'b0;
    repeat (3) tick();

    // flush at level 6 keeps the drop count
    for (int i = 0; i < 6; i++) push(8'(8'hB0 + i));
    chk("flush6_pre_level", o_level, 6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush6_level", o_level, 0);
    chk("flush6_empty", o_empty, 1);
    chk("flush6_drop", o_drop_cnt, 4);

    // async reset in WAIT_ACK
    push(8'hD1); push(8'hD2);
    tx_ready = 1'b1;
    wait_issue(got);
    chk("rstmid_issued", got, 1);
    chk("rstmid_level", o_level, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", o_tx_valid, 0);
    chk("rstmid_data", o_tx_data, 0);
    chk("rstmid_level0", o_level, 0);
    chk("rstmid_empty", o_empty, 1);
    chk("rstmid_drop", o_drop_cnt, 0);
    chk("rstmid_ovf", o_overflow, 0);
    chk("rstmid_to", o_timeout, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_loopback_bridge.md
Name: uart_loopback_bridge

Overview:
- Parametrised rx-to-tx bridge between the receive and transmit user interfaces of uart_drive.
- Buffers received bytes in an internal synchronous FIFO.
- Issues each buffered word to the transmitter as a single-cycle valid pulse. After each issue it locks until the transmitter acknowledges by dropping ready, so no word is ever double-issued.
- Adds over the existing loopback: runtime enable and flush, fill level and almost-full flag, overflow drop counter, and an acknowledge timeout.

Parameters:
DATA_W, 8, width of rx/tx data words
DEPTH, 16, FIFO depth in words; power of two, >= 2
AF_THRESH, 14, o_almost_full asserted when level >= AF_THRESH (1..DEPTH)
ACK_TIMEOUT, 1024, cycles to wait in WAIT_ACK for ready to fall; 0 disables the timeout
CNT_W, 16, width of the drop counter

Ports:
i_clk  in  1  single clock; all logic on the rising edge
i_rst_n  in  1  asynchronous, active-low reset
i_rx_data  in  DATA_W  received word
i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
i_loop_en  in  1  1: accept rx words into the FIFO; 0: ignore rx strobes (not counted as drops)
i_flush  in  1  synchronous flush of FIFO contents
i_tx_ready  in  1  transmitter idle
o_tx_data  out  DATA_W  word to transmit; held stable until the next issue
o_tx_valid  out  1  one-cycle issue pulse
o_level  out  $clog2(DEPTH)+1  current FIFO occupancy
o_empty  out  1  level == 0
o_full  out  1  level == DEPTH
o_almost_full  out  1  level >= AF_THRESH
o_overflow  out  1  one-cycle pulse when an rx word is dropped because the FIFO is full
o_drop_cnt  out  CNT_W  saturating count of dropped words
o_timeout  out  1  one-cycle pulse on acknowledge timeout

Behaviour:
- Reset (async assert, sync release): pointers, o_level, o_tx_data, o_tx_valid, o_overflow, o_drop_cnt, o_timeout = 0; o_empty = 1; o_full = 0; o_almost_full = 0; FSM = IDLE; timeout counter = 0.
- Write: wr = i_rx_valid & i_loop_en & ~i_flush.
  - If wr & ~full: store word at wr_ptr, wr_ptr++ (wraps mod DEPTH).
  - If wr & full: word discarded; o_overflow pulses next cycle; o_drop_cnt increments, saturating at all-ones.
- Pop: occurs only in IDLE when i_tx_ready & ~empty & ~i_flush.
  - On the pop edge: o_tx_data <= mem[rd_ptr], o_tx_valid <= 1 for one cycle, rd_ptr++, FSM -> WAIT_ACK.
- Latency: a word strobed at edge N is counted in o_level after N. With i_tx_ready high and the FIFO previously empty, o_tx_valid is high after edge N+1.
- Simultaneous write and pop (FIFO not full): both take effect and o_level is unchanged. When full, a same-cycle write is still dropped; full is evaluated before the pop.
- Flags (o_empty, o_full, o_almost_full) are registered together with o_level and are consistent with it every cycle.
- FSM:
  - IDLE: pop condition true -> WAIT_ACK.
  - WAIT_ACK: i_tx_ready == 0 -> WAIT_DONE. The first cycle after the issue ignores ready, because the transmitter may need one cycle to drop it.
  - WAIT_ACK, ACK_TIMEOUT != 0: if ready has not fallen within ACK_TIMEOUT cycles of the issue -> o_timeout pulses, FSM -> IDLE. The word is considered lost and is not re-issued.
  - WAIT_DONE: i_tx_ready == 1 -> IDLE. The next pop can occur on the following edge at the earliest.
- Flush:
  - Pointers and level are cleared in the flush cycle; flush has priority over write and pop in that cycle.
  - FSM is not affected, so an already-issued word completes its handshake normally.
  - o_drop_cnt is not cleared by flush.
- i_loop_en low: rx strobes are ignored; draining to the transmitter continues.
- Reset mid-transfer: state is discarded and o_tx_valid goes low immediately. The transmitter must be reset by the same reset.

Decomposition:
- Shared package uart_pkg: DATA_W default, FSM state encoding (IDLE / WAIT_ACK / WAIT_DONE), and the level width function (clog2-based).
- One sub-module, sync_fifo_lvl: the parametrised DEPTH x DATA_W FIFO with level and flags, plus the flush input.
- Handshake FSM, timeout counter and drop counter live in the top of uart_loopback_bridge.

Test Plan:
- Basic echo: strobe 0x55 with i_tx_ready=1 -> o_tx_valid after 2 edges with o_tx_data=0x55; drop ready 1 cycle later, raise it 10 cycles later -> exactly one pulse.
- Burst with slow transmitter: 5 words 0x01..0x05 while ready=0 -> o_level=5. Then let ready cycle (drop 1 cycle after each issue, raise 100 cycles later) -> 5 issues in order, 0x01..0x05, no duplicates even though ready stays high more than 1 cycle.
- Overflow: DEPTH=16, ready=0, 20 strobes -> o_full=1, 4 o_overflow pulses, o_drop_cnt=4. o_almost_full rises when level reaches 14.
- Simultaneous write/pop at level 3 -> o_level stays 3. Wrap-around: push/pop 40 words with DEPTH=16 -> data intact.
- Timeout: ACK_TIMEOUT=8, ready held 1 after issue -> o_timeout pulse 8 cycles after the issue, FSM back to IDLE, next word issued.
- Flush and loop_en:
  - i_flush at level 6 -> level 0, o_empty=1, drop count kept.
  - i_loop_en=0 with strobes -> level unchanged, o_drop_cnt unchanged.
  - Async reset mid-WAIT_ACK -> all outputs at reset values.
